// File: rtl/decode_exec_pipe_reg.sv
// decode_exec_pipe_reg
//
// Decode -> Execute pipeline register with a two-entry elastic buffer:
// a main entry that drives the E outputs and a skid entry that absorbs one
// extra instruction while Execute back-pressures.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and its payload) until it sees ready.
// readyD depends only on registered state, so there is no combinational
// path from readyE to readyD. FlushE kills everything held plus the
// instruction offered in the same cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   validD / readyD     Decode-side handshake
//   validE / readyE     Execute-side handshake
//   FlushE              synchronous kill of held and incoming instructions
//   *D inputs           decoded instruction payload
//   *E outputs          payload of the main entry; write/jump/branch strobes
//                       are forced low while validE is low
//   stall_cnt           saturating count of back-pressure cycles
module decode_exec_pipe_reg #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5,
   parameter int ALUC_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validD,
   output logic              readyD,
   output logic              validE,
   input  logic              readyE,
   input  logic              FlushE,
   input  logic              RegWriteD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic              JALRctrlD,
   input  logic [1:0]        ResultSrcD,
   input  logic [ALUC_W-1:0] ALUControlD,
   input  logic [WIDTH-1:0]  RD1D,
   input  logic [WIDTH-1:0]  RD2D,
   input  logic [WIDTH-1:0]  PCD,
   input  logic [WIDTH-1:0]  ImmExtD,
   input  logic [WIDTH-1:0]  PCPlus4D,
   input  logic [REG_AW-1:0] RdD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   output logic              RegWriteE,
   output logic              MemWriteE,
   output logic              JumpE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic              JALRctrlE,
   output logic [1:0]        ResultSrcE,
   output logic [ALUC_W-1:0] ALUControlE,
   output logic [WIDTH-1:0]  RD1E,
   output logic [WIDTH-1:0]  RD2E,
   output logic [WIDTH-1:0]  PCE,
   output logic [WIDTH-1:0]  ImmExtE,
   output logic [WIDTH-1:0]  PCPlus4E,
   output logic [REG_AW-1:0] RdE,
   output logic [REG_AW-1:0] Rs1E,
   output logic [REG_AW-1:0] Rs2E,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Six 1-bit strobes, 2-bit ResultSrc, ALUControl, five words, three addresses.
   localparam int PW = 8 + ALUC_W + 5 * WIDTH + 3 * REG_AW;

   logic [PW-1:0] din;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic          main_valid;
   logic          skid_valid;
   logic          accept;
   logic          consume;

   logic rw_q, mw_q, jump_q, branch_q, jalr_q;

   assign din = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD,
                 ResultSrcD, ALUControlD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
                 RdD, Rs1D, Rs2D};

   assign readyD  = ~skid_valid;
   assign validE  = main_valid;
   assign accept  = validD & readyD & ~FlushE;
   assign consume = main_valid & readyE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (FlushE) begin
         // Payload is left as-is; bubble gating hides the stale strobes.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (consume || !main_valid) begin
         // Main slot frees up this edge. The skid entry is older than
         // anything on the input, and readyD was low, so no accept competes.
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= din;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         // Main is held by back-pressure: park the newcomer in the skid slot.
         skid_q     <= din;
         skid_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (main_valid && !readyE && !FlushE && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign {rw_q, mw_q, jump_q, branch_q, ALUSrcE, jalr_q,
           ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
           RdE, Rs1E, Rs2E} = main_q;

   // Side-effecting strobes must never fire from a bubble.
   assign RegWriteE = rw_q     & main_valid;
   assign MemWriteE = mw_q     & main_valid;
   assign JumpE     = jump_q   & main_valid;
   assign BranchE   = branch_q & main_valid;
   assign JALRctrlE = jalr_q   & main_valid;

endmodule

// File: tb/tb_decode_exec_pipe_reg.sv
module tb_decode_exec_pipe_reg;

   localparam int WIDTH  = 32;
   localparam int REG_AW = 5;
   localparam int ALUC_W = 3;
   localparam int CNT_W  = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              validD = 1'b0, readyE = 1'b0, FlushE = 1'b0;
   logic              readyD, validE;
   logic              RegWriteD = 1'b0, MemWriteD = 1'b0, JumpD = 1'b0;
   logic              BranchD = 1'b0, ALUSrcD = 1'b0, JALRctrlD = 1'b0;
   logic [1:0]        ResultSrcD = '0;
   logic [ALUC_W-1:0] ALUControlD = '0;
   logic [WIDTH-1:0]  RD1D = '0, RD2D = '0, PCD = '0, ImmExtD = '0, PCPlus4D = '0;
   logic [REG_AW-1:0] RdD = '0, Rs1D = '0, Rs2D = '0;
   logic              RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRctrlE;
   logic [1:0]        ResultSrcE;
   logic [ALUC_W-1:0] ALUControlE;
   logic [WIDTH-1:0]  RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
   logic [REG_AW-1:0] RdE, Rs1E, Rs2E;
   logic [CNT_W-1:0]  stall_cnt;

   decode_exec_pipe_reg #(.WIDTH(WIDTH), .REG_AW(REG_AW), .ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .validD(validD), .readyD(readyD), .validE(validE),
      .readyE(readyE), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
      .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD), .ResultSrcD(ResultSrcD),
      .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
      .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
      .ALUSrcE(ALUSrcE), .JALRctrlE(JALRctrlE), .ResultSrcE(ResultSrcE),
      .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
      .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .stall_cnt(stall_cnt)
   );

   // ---------------- scoreboard state ----------------
   logic [WIDTH-1:0] exp_q[$];        // PCs of held instructions, oldest first
   logic [CNT_W-1:0] exp_stall = '0;
   int               n_checks = 0;
   int               n_fail   = 0;

   // ---------------- driver tasks ----------------
   // Called at a falling edge: applies inputs, crosses one rising edge,
   // updates the reference model, and returns at the next falling edge.
   task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic [REG_AW-1:0] rd,
                        input logic re, input logic fl);
      logic acc, cons;
      validD = v; readyE = re; FlushE = fl;
      PCD = pc; RD1D = pc + 32'h1; RD2D = pc + 32'h2; ImmExtD = ~pc; PCPlus4D = pc + 32'h4;
      RdD = rd; Rs1D = rd + 5'd1; Rs2D = rd + 5'd2;
      ALUControlD = pc[4:2]; ResultSrcD = pc[3:2];
      {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD} = 6'b111111;
      acc  = v && (exp_q.size() < 2) && !fl;
      cons = (exp_q.size() > 0) && re;
      @(posedge clk);
      if ((exp_q.size() > 0) && !re && !fl && (exp_stall != 4'hF)) exp_stall = exp_stall + 4'd1;
      if (fl) exp_q.delete();
      else begin
         if (cons) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(pc);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      validD = 1'b0; readyE = 1'b0; FlushE = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_stall = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      validD = 1'b0; readyE = 1'b0; FlushE = 1'b0;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++; if (validE !== 1'b0) begin n_fail++; $display("FAIL reset_validE: got %b want 0", validE); end
      n_checks++; if (readyD !== 1'b1) begin n_fail++; $display("FAIL reset_readyD: got %b want 1", readyD); end
      n_checks++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
      n_checks++; if (PCE !== 32'h0 || RD1E !== 32'h0 || RdE !== 5'd0) begin n_fail++; $display("FAIL reset_payload: PCE %h RD1E %h RdE %0d want 0", PCE, RD1E, RdE); end
      rst = 1'b0;
      exp_q.delete(); exp_stall = '0;
      @(negedge clk);
      n_checks++; if (readyD !== 1'b1) begin n_fail++; $display("FAIL post_reset_readyD: got %b want 1", readyD); end
   endtask

   task automatic test_single();
      do_reset();
      drive(1'b1, 32'h100, 5'd7, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b1) begin n_fail++; $display("FAIL single_validE: got %b want 1", validE); end
      n_checks++; if (RdE !== 5'd7) begin n_fail++; $display("FAIL single_RdE: got %0d want 7", RdE); end
      n_checks++; if (PCE !== 32'h100) begin n_fail++; $display("FAIL single_PCE: got %h want 100", PCE); end
      n_checks++; if (readyD !== 1'b1) begin n_fail++; $display("FAIL single_readyD: got %b want 1", readyD); end
      n_checks++; if (PCPlus4E !== 32'h104 || ImmExtE !== 32'hFFFF_FEFF || Rs2E !== 5'd9) begin n_fail++; $display("FAIL single_fields: PCPlus4E %h ImmExtE %h Rs2E %0d want 104 fffffeff 9", PCPlus4E, ImmExtE, Rs2E); end
      n_checks++; if (RegWriteE !== 1'b1 || JALRctrlE !== 1'b1) begin n_fail++; $display("FAIL single_ctrl: RegWriteE %b JALRctrlE %b want 1 1", RegWriteE, JALRctrlE); end
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b0) begin n_fail++; $display("FAIL drain_validE: got %b want 0", validE); end
      n_checks++; if (RegWriteE !== 1'b0 || MemWriteE !== 1'b0) begin n_fail++; $display("FAIL bubble_gate: RegWriteE %b MemWriteE %b want 0 0", RegWriteE, MemWriteE); end
      n_checks++; if (PCE !== 32'h100 || ALUSrcE !== 1'b1) begin n_fail++; $display("FAIL bubble_hold: PCE %h ALUSrcE %b want 100 1", PCE, ALUSrcE); end
   endtask

   task automatic test_skid_order();
      do_reset();
      drive(1'b1, 32'h100, 5'd1, 1'b0, 1'b0);
      n_checks++; if (PCE !== 32'h100 || readyD !== 1'b1 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL skid_A: PCE %h readyD %b stall %0d want 100 1 0", PCE, readyD, stall_cnt); end
      drive(1'b1, 32'h104, 5'd2, 1'b0, 1'b0);
      n_checks++; if (PCE !== 32'h100 || readyD !== 1'b0 || stall_cnt !== 4'd1) begin n_fail++; $display("FAIL skid_B: PCE %h readyD %b stall %0d want 100 0 1", PCE, readyD, stall_cnt); end
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      n_checks++; if (PCE !== 32'h100 || RdE !== 5'd1 || readyD !== 1'b0 || stall_cnt !== 4'd2) begin n_fail++; $display("FAIL skid_hold: PCE %h RdE %0d readyD %b stall %0d want 100 1 0 2", PCE, RdE, readyD, stall_cnt); end
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b1 || PCE !== 32'h104 || RdE !== 5'd2 || readyD !== 1'b1) begin n_fail++; $display("FAIL skid_out_B: validE %b PCE %h RdE %0d readyD %b want 1 104 2 1", validE, PCE, RdE, readyD); end
      n_checks++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL skid_stall_hold: got %0d want 2", stall_cnt); end
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b0) begin n_fail++; $display("FAIL skid_empty: validE %b want 0", validE); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1'b1, 32'h100, 5'd1, 1'b0, 1'b0);
      drive(1'b1, 32'h104, 5'd2, 1'b0, 1'b0);
      drive(1'b1, 32'h200, 5'd3, 1'b0, 1'b1);
      n_checks++; if (validE !== 1'b0 || readyD !== 1'b1) begin n_fail++; $display("FAIL flush_state: validE %b readyD %b want 0 1", validE, readyD); end
      n_checks++; if ({RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE} !== 5'b0) begin n_fail++; $display("FAIL flush_gate: strobes %b want 00000", {RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE}); end
      n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_stall: got %0d want 1", stall_cnt); end
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: validE %b PCE %h want 0", validE, PCE); end
      drive(1'b1, 32'h300, 5'd4, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b1 || PCE !== 32'h300) begin n_fail++; $display("FAIL flush_next: validE %b PCE %h want 1 300", validE, PCE); end
   endtask

   task automatic test_stall_sat();
      do_reset();
      drive(1'b1, 32'h500, 5'd5, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      n_checks++; if (stall_cnt !== 4'd14) begin n_fail++; $display("FAIL stall_14: got %0d want 14", stall_cnt); end
      for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", stall_cnt); end
      n_checks++; if (validE !== 1'b1 || PCE !== 32'h500) begin n_fail++; $display("FAIL stall_stable: validE %b PCE %h want 1 500", validE, PCE); end
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      n_checks++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_flush_keep: got %0d want 15", stall_cnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 32'h100, 5'd1, 1'b0, 1'b0);
      drive(1'b1, 32'h104, 5'd2, 1'b0, 1'b0);
      validD = 1'b0; readyE = 1'b0; FlushE = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_checks++; if (validE !== 1'b0 || readyD !== 1'b1 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL async_state: validE %b readyD %b stall %0d want 0 1 0", validE, readyD, stall_cnt); end
      n_checks++; if (PCE !== 32'h0 || RegWriteE !== 1'b0 || RdE !== 5'd0) begin n_fail++; $display("FAIL async_payload: PCE %h RegWriteE %b RdE %0d want 0", PCE, RegWriteE, RdE); end
      #1 rst = 1'b0;
      exp_q.delete(); exp_stall = '0;
      @(negedge clk);
      drive(1'b1, 32'h400, 5'd9, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b1 || PCE !== 32'h400 || RdE !== 5'd9) begin n_fail++; $display("FAIL async_first: validE %b PCE %h RdE %0d want 1 400 9", validE, PCE, RdE); end
      drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (validE !== 1'b0) begin n_fail++; $display("FAIL async_no_stale: validE %b PCE %h want 0", validE, PCE); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] pc;
      do_reset();
      pc = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
         n_checks++; if (validE !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_validE cyc %0d: got %b want %b", i, validE, exp_q.size() > 0); end
         n_checks++; if (readyD !== (exp_q.size() < 2)) begin n_fail++; $display("FAIL rnd_readyD cyc %0d: got %b want %b", i, readyD, exp_q.size() < 2); end
         n_checks++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d: got %0d want %0d", i, stall_cnt, exp_stall); end
         n_checks++; if (RegWriteE !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_gate cyc %0d: got %b want %b", i, RegWriteE, exp_q.size() > 0); end
         if (exp_q.size() > 0) begin
            n_checks++; if (PCE !== exp_q[0] || RdE !== exp_q[0][6:2] || PCPlus4E !== exp_q[0] + 32'h4) begin n_fail++; $display("FAIL rnd_order cyc %0d: PCE %h RdE %0d PCPlus4E %h want PC %h", i, PCE, RdE, PCPlus4E, exp_q[0]); end
         end
         drive(1'($urandom_range(0, 3) != 0), pc, pc[6:2], 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 31) == 0));
         pc = pc + 32'h4;
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_skid_order();
      test_flush();
      test_stall_sat();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_exec_pipe_reg.md
DECODE_EXEC_PIPE_REG -- requirements
Module: decode_exec_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of RD1/RD2/PC/ImmExt/PCPlus4 fields.
REQ-002 Parameter REG_AW, default 5, register-address width of Rd/Rs1/Rs2 fields.
REQ-003 Parameter ALUC_W, default 3, ALUControl width.
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 validD  input  1  Decode presents an instruction this cycle.
REQ-008 readyD  output  1  block can accept a Decode instruction this cycle.
REQ-009 validE  output  1  Execute-side entry holds a live instruction.
REQ-010 readyE  input  1  Execute consumes the presented entry this cycle.
REQ-011 FlushE  input  1  synchronous kill of all held and incoming instructions.
REQ-012 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD  input  1 each  control strobes.
REQ-013 ResultSrcD  input  2; ALUControlD  input  ALUC_W.
REQ-014 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  input  WIDTH each; RdD, Rs1D, Rs2D  input  REG_AW each.
REQ-015 Matching E-suffixed outputs for every D-suffixed field in REQ-012..014, same widths.
REQ-016 stall_cnt  output  CNT_W  saturating count of Execute back-pressure cycles.

Function
REQ-017 Storage: one main entry (drives E outputs) plus one skid entry, each holding full payload and a valid bit.
REQ-018 Transfer rules: accept = validD & readyD & ~FlushE; consume = validE & readyE.
REQ-019 readyD SHALL equal ~skid_valid (combinational, registered state only; no path from readyE).
REQ-020 Main empty or consumed, skid empty: accepted input loads main next cycle (latency 1 cycle D->E).
REQ-021 Main full, not consumed, accept: input captured into skid; main unchanged.
REQ-022 Main consumed, skid full: skid moves into main, skid empties; readyD was 0 so no accept that cycle.
REQ-023 Main consumed, skid empty, no accept: validE clears next cycle.
REQ-024 Ordering: instructions SHALL leave in acceptance order; no drop or duplication without FlushE.
REQ-025 FlushE: next cycle validE=0 and skid_valid=0; input in the flush cycle discarded; FlushE overrides accept and consume.
REQ-026 Bubble gating: when validE=0, RegWriteE, MemWriteE, JumpE, BranchE, JALRctrlE SHALL read 0 regardless of stored payload; other E outputs hold last stored values.
REQ-027 Main entry payload SHALL not change while validE=1 and readyE=0 (stable under back-pressure).
REQ-028 stall_cnt increments by 1 each cycle validE=1 & readyE=0 & FlushE=0; holds at 2^CNT_W-1; never wraps; not cleared by FlushE.
REQ-029 Fields are passed unmodified; no arithmetic on payload.

Reset
REQ-030 rst=1 asynchronously forces validE=0, skid_valid=0, all payload registers 0, stall_cnt=0; readyD reads 1 during and after reset.
REQ-031 Reset asserted mid-transfer discards both entries; first accept after rst deasserts behaves per REQ-020.

Verification
REQ-032 Reset, then validD=1 with RdD=5'd7, PCD=32'h100, readyE=1 -> next cycle validE=1, RdE=7, PCE=32'h100, readyD=1.
REQ-033 readyE=0, send A (PC 0x100) then B (PC 0x104) -> main=A, skid=B, readyD=0, stall_cnt increments each cycle; raise readyE -> A out, then B, in order.
REQ-034 Main and skid full, FlushE=1 with validD=1 -> next cycle validE=0, readyD=1, RegWriteE=MemWriteE=JumpE=BranchE=JALRctrlE=0, flushed input never appears.
REQ-035 CNT_W=4, hold validE=1 readyE=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-036 rst pulsed between clock edges with both entries full -> outputs zero immediately, validE=0, stall_cnt=0.
REQ-037 Random validD/readyE/FlushE for 10k cycles against a scoreboard queue -> zero ordering, loss or duplication errors.
